// File: rtl/ascii_dec_parser.sv
// Purpose : streaming ASCII-decimal to binary parser, one result per digit run.
// Latency : result registered at the edge that accepts the terminating delimiter.
// Backpressure: in_ready drops while a result is pending; the result holds until out_ready.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid/in_ready/in_data      ASCII character input handshake
//   out_valid/out_ready            result handshake
//   out_value[W-1:0]               parsed value, saturated to all ones on overflow
//   out_ndig[3:0]                  digits in the run, saturating at 15
//   out_ovf                        value exceeded 2^W-1 at some point in the run

// Character classifier: digit value 0..9 for '0'..'9', 15 for anything else.
module text2nibble (
  input  logic [7:0] ch,
  output logic [3:0] nib
);
  always_comb begin
    nib = 4'hF;
    if (ch >= 8'h30 && ch <= 8'h39) nib = ch[3:0];
  end
endmodule

module ascii_dec_parser #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_value,
  output logic [3:0]   out_ndig,
  output logic         out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t       state;
  logic [W-1:0] acc;
  logic [3:0]   ndig;
  logic         ovf;

  logic [3:0]   nib;
  logic         digit;
  logic         accept;
  logic [W+3:0] acc_ext;
  logic [W+3:0] next_val;
  logic         next_ovf;
  logic [3:0]   ndig_inc;
  logic [W-1:0] nib_w;

  text2nibble u_t2n (
    .ch  (in_data),
    .nib (nib)
  );

  assign digit  = (nib != 4'hF);
  // Pure state decode: no path from in_valid, low while reset is held.
  assign in_ready = rst_n && (state != DONE);
  assign accept   = in_valid && in_ready;

  // acc*10 + nib fits in W+4 bits since 10*(2^W-1)+9 < 2^(W+4).
  assign acc_ext  = {4'b0000, acc};
  assign next_val = (acc_ext << 3) + (acc_ext << 1) + {{W{1'b0}}, nib};
  // Once a run overflows it stays saturated regardless of later digits.
  assign next_ovf = ovf || (|next_val[W+3:W]);
  assign ndig_inc = (ndig == 4'hF) ? 4'hF : ndig + 4'd1;
  assign nib_w    = W'(nib);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      ndig      <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_ndig  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Non-digits here are leading delimiters/whitespace: dropped.
          if (accept && digit) begin
            acc   <= nib_w;
            ndig  <= 4'd1;
            ovf   <= 1'b0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (digit) begin
              if (next_ovf) begin
                acc <= '1;
                ovf <= 1'b1;
              end else begin
                acc <= next_val[W-1:0];
              end
              ndig <= ndig_inc;
            end else begin
              // Delimiter is consumed, not forwarded.
              out_value <= acc;
              out_ndig  <= ndig;
              out_ovf   <= ovf;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            ndig      <= '0;
            ovf       <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_dec_parser.sv
module tb_ascii_dec_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_value;
  logic [3:0]  out_ndig;
  logic        out_ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int v;
    int nd;
    int ov;
  } res_t;

  typedef struct {
    string s;
    int    v;
    int    nd;
    int    ov;
  } vec_t;

  res_t res_q[$];
  int   len_q[$];
  bit   was_valid = 1'b0;
  int   hi_len = 0;

  ascii_dec_parser #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_ndig  (out_ndig),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    res_t r;
    #1;
    if (out_valid) begin
      if (!was_valid) begin
        r.v  = int'(out_value);
        r.nd = int'(out_ndig);
        r.ov = int'(out_ovf);
        res_q.push_back(r);
      end
      hi_len++;
      check("in_ready_low_while_done", int'(in_ready), 0);
    end else begin
      if (was_valid) len_q.push_back(hi_len);
      hi_len = 0;
    end
    was_valid = out_valid;
  end

  // Idle gap cycles drive a digit on in_data with in_valid low; it must be ignored.
  task automatic send(input logic [7:0] c, input int gap);
    int n;
    in_valid = 1'b0;
    in_data  = 8'h37;
    for (int i = 0; i < gap; i++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = c;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'h37;
  endtask

  task automatic send_str(input string s, input bit rnd_gap);
    for (int i = 0; i < s.len(); i++)
      send(s[i], rnd_gap ? int'($urandom_range(0, 4)) : 0);
  endtask

  task automatic wait_results(input int n);
    int k;
    k = 0;
    while (res_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (res_q.size() < n) check("result_timeout", res_q.size(), n);
  endtask

  task automatic settle(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  task automatic clear_q();
    res_q.delete();
    len_q.delete();
  endtask

  initial begin
    vec_t tbl[8];
    res_t r;

    tbl[0] = '{"123\n",                65535 & 123, 3,  0};
    tbl[1] = '{"007 ",                 7,           3,  0};
    tbl[2] = '{"65535 ",               65535,       5,  0};
    tbl[3] = '{"65536 ",               65535,       5,  1};
    tbl[4] = '{"99999999999999999 ",   65535,       15, 1};
    tbl[5] = '{"0,",                   0,           1,  0};
    tbl[6] = '{"70000x",               65535,       5,  1};
    tbl[7] = '{"6553;",                6553,        4,  0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_value", int'(out_value), 0);
    check("post_rst_out_ndig", int'(out_ndig), 0);
    check("post_rst_out_ovf", int'(out_ovf), 0);

    // Table of single-run strings, out_ready held high
    for (int i = 0; i < 8; i++) begin
      clear_q();
      send_str(tbl[i].s, 1'b0);
      check($sformatf("vec%0d_valid_at_delim", i), int'(out_valid), 1);
      wait_results(1);
      settle(2);
      if (res_q.size() > 0) begin
        r = res_q[0];
        check($sformatf("vec%0d_value", i), r.v, tbl[i].v);
        check($sformatf("vec%0d_ndig", i), r.nd, tbl[i].nd);
        check($sformatf("vec%0d_ovf", i), r.ov, tbl[i].ov);
      end
      check($sformatf("vec%0d_nresults", i), res_q.size(), 1);
      if (len_q.size() > 0) check($sformatf("vec%0d_pulse_len", i), len_q[0], 1);
      else check($sformatf("vec%0d_pulse_len_missing", i), 0, 1);
    end

    // Two runs with random idle gaps and leading spaces
    clear_q();
    send_str("  42,7;", 1'b1);
    wait_results(2);
    settle(2);
    check("gap_nresults", res_q.size(), 2);
    if (res_q.size() >= 2) begin
      check("gap_r0_value", res_q[0].v, 42);
      check("gap_r0_ndig", res_q[0].nd, 2);
      check("gap_r0_ovf", res_q[0].ov, 0);
      check("gap_r1_value", res_q[1].v, 7);
      check("gap_r1_ndig", res_q[1].nd, 1);
      check("gap_r1_ovf", res_q[1].ov, 0);
    end

    // Backpressure: result must hold while out_ready is low
    clear_q();
    out_ready = 1'b0;
    send_str("5A", 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_value", int'(out_value), 5);
      check("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", int'(out_valid), 0);
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_hold_value_after", int'(out_value), 5);
    check("bp_nresults", res_q.size(), 1);

    // Reset in the middle of a run discards the partial digits
    clear_q();
    send_str("98", 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_out_value", int'(out_value), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_str("3 ", 1'b0);
    wait_results(1);
    settle(3);
    check("midrst_nresults", res_q.size(), 1);
    if (res_q.size() > 0) begin
      check("midrst_value", res_q[0].v, 3);
      check("midrst_ndig", res_q[0].nd, 1);
      check("midrst_ovf", res_q[0].ov, 0);
    end

    // Every non-digit byte in IDLE is dropped without producing a result
    clear_q();
    for (int b = 0; b < 256; b++) begin
      if (b < 8'h30 || b > 8'h39) send(8'(b), 0);
    end
    settle(3);
    check("sweep_nresults", res_q.size(), 0);
    check("sweep_in_ready", int'(in_ready), 1);
    check("sweep_out_valid", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
